// File: rtl/way_alloc_ctrl.sv
// way_alloc_ctrl: scans one set way by way and picks the fill way (first invalid, else LRU),
// running a writeback handshake first when the LRU victim is Modified.
module way_alloc_ctrl #(
    parameter int WAYS       = 8,
    parameter int WAY_BITS   = 3,
    parameter int INDEX_BITS = 14,
    parameter int TAG_BITS   = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [INDEX_BITS-1:0] req_index_i,
    output logic                  rd_en_o,
    output logic [INDEX_BITS-1:0] rd_index_o,
    output logic [WAY_BITS-1:0]   rd_way_o,
    input  logic [1:0]            rd_mesi_i,
    input  logic [WAY_BITS-1:0]   rd_lru_i,
    input  logic [TAG_BITS-1:0]   rd_tag_i,
    output logic                  wb_valid_o,
    input  logic                  wb_ready_i,
    output logic [INDEX_BITS-1:0] wb_index_o,
    output logic [TAG_BITS-1:0]   wb_tag_o,
    output logic [WAY_BITS-1:0]   wb_way_o,
    output logic                  alloc_valid_o,
    output logic [WAY_BITS-1:0]   alloc_way_o,
    output logic                  alloc_evict_o
);
    typedef enum logic [1:0] {IDLE, SCAN, WB, DONE} state_t;
    localparam logic [WAY_BITS-1:0] LAST = WAY_BITS'(WAYS - 1);
    state_t                state_q, state_d;
    logic [INDEX_BITS-1:0] idx_q, idx_d;
    logic                  rd_en_q, rd_en_d;
    logic [WAY_BITS-1:0]   rd_way_q, rd_way_d;
    logic                  pend_q;
    logic [WAY_BITS-1:0]   pend_way_q;
    logic                  have_q, have_d;
    logic [WAY_BITS-1:0]   best_q, best_d;
    logic [WAY_BITS-1:0]   vic_q, vic_d;
    logic [TAG_BITS-1:0]   tag_q, tag_d;
    logic                  m_q, m_d;
    logic                  evict_q, evict_d;
    logic                  req_ready_q, wb_valid_q, alloc_valid_q;
    logic                  resp, hit_inv, upd, last;

    // pend_q marks that rd_mesi/rd_lru/rd_tag this cycle answer the read issued last cycle
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        rd_en_d  = 1'b0;
        rd_way_d = rd_way_q;
        have_d   = have_q;
        best_d   = best_q;
        vic_d    = vic_q;
        tag_d    = tag_q;
        m_d      = m_q;
        evict_d  = evict_q;
        resp     = pend_q && state_q == SCAN;
        hit_inv  = resp && rd_mesi_i == 2'b00;
        upd      = resp && !hit_inv && (!have_q || rd_lru_i > best_q);
        last     = resp && pend_way_q == LAST;
        case (state_q)
            IDLE: if (req_ready_q && req_valid_i) begin
                state_d  = SCAN;
                idx_d    = req_index_i;
                rd_en_d  = 1'b1;
                rd_way_d = '0;
                have_d   = 1'b0;
                best_d   = '0;
                vic_d    = '0;
                tag_d    = '0;
                m_d      = 1'b0;
                evict_d  = 1'b0;
            end
            SCAN: begin
                rd_en_d  = rd_en_q && rd_way_q != LAST;
                rd_way_d = rd_en_d ? rd_way_q + 1'b1 : rd_way_q;
                if (upd) begin
                    have_d = 1'b1;
                    best_d = rd_lru_i;
                    vic_d  = pend_way_q;
                    tag_d  = rd_tag_i;
                    m_d    = rd_mesi_i == 2'b11;
                end
                if (hit_inv) begin
                    vic_d   = pend_way_q;
                    evict_d = 1'b0;
                    rd_en_d = 1'b0;
                    state_d = DONE;
                end else if (last) begin
                    evict_d = 1'b1;
                    state_d = m_d ? WB : DONE;
                end
            end
            WB:      state_d = wb_ready_i ? DONE : WB;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            rd_en_q       <= 1'b0;
            rd_way_q      <= '0;
            pend_q        <= 1'b0;
            pend_way_q    <= '0;
            have_q        <= 1'b0;
            best_q        <= '0;
            vic_q         <= '0;
            tag_q         <= '0;
            m_q           <= 1'b0;
            evict_q       <= 1'b0;
            req_ready_q   <= 1'b0;
            wb_valid_q    <= 1'b0;
            alloc_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            rd_en_q       <= rd_en_d;
            rd_way_q      <= rd_way_d;
            pend_q        <= rd_en_q;
            pend_way_q    <= rd_way_q;
            have_q        <= have_d;
            best_q        <= best_d;
            vic_q         <= vic_d;
            tag_q         <= tag_d;
            m_q           <= m_d;
            evict_q       <= evict_d;
            req_ready_q   <= state_d == IDLE;
            wb_valid_q    <= state_d == WB;
            alloc_valid_q <= state_d == DONE;
        end
    end

    assign req_ready_o   = req_ready_q;
    assign rd_en_o       = rd_en_q;
    assign rd_index_o    = idx_q;
    assign rd_way_o      = rd_way_q;
    assign wb_valid_o    = wb_valid_q;
    assign wb_index_o    = idx_q;
    assign wb_tag_o      = tag_q;
    assign wb_way_o      = vic_q;
    assign alloc_valid_o = alloc_valid_q;
    assign alloc_way_o   = vic_q;
    assign alloc_evict_o = evict_q;
endmodule

// File: tb/tb_way_alloc_ctrl.sv
// tb_way_alloc_ctrl: table-driven and random allocation requests against a set-content model,
// plus hand sequences for reset during writeback and a request held while busy.
module tb_way_alloc_ctrl;
    localparam int WAYS = 8;
    typedef struct {
        logic [13:0]      idx;
        logic [7:0][1:0]  mesi;
        logic [7:0][2:0]  lru;
        logic [7:0][11:0] tag;
        int               wb_start;
        int               e_way;
        bit               e_evict;
        bit               e_wb;
        int               e_cyc;
        logic [11:0]      e_tag;
    } vec_t;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        req_valid = 1'b0, wb_ready = 1'b0;
    logic [13:0] req_index = '0;
    logic [1:0]  rd_mesi = '0;
    logic [2:0]  rd_lru = '0;
    logic [11:0] rd_tag = '0;
    logic        req_ready_o, rd_en_o, wb_valid_o, alloc_valid_o, alloc_evict_o;
    logic [13:0] rd_index_o, wb_index_o;
    logic [2:0]  rd_way_o, wb_way_o, alloc_way_o;
    logic [11:0] wb_tag_o;
    int          checks = 0, errors = 0;
    vec_t        cur, tbl[5];
    logic        pv = 1'b0;
    logic [2:0]  pw = '0;

    way_alloc_ctrl dut (
        .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready_o),
        .req_index_i(req_index), .rd_en_o(rd_en_o), .rd_index_o(rd_index_o), .rd_way_o(rd_way_o),
        .rd_mesi_i(rd_mesi), .rd_lru_i(rd_lru), .rd_tag_i(rd_tag), .wb_valid_o(wb_valid_o),
        .wb_ready_i(wb_ready), .wb_index_o(wb_index_o), .wb_tag_o(wb_tag_o), .wb_way_o(wb_way_o),
        .alloc_valid_o(alloc_valid_o), .alloc_way_o(alloc_way_o), .alloc_evict_o(alloc_evict_o)
    );

    always #5 clk = ~clk;

    // array model: answer the read issued in the previous cycle, random noise otherwise
    always @(negedge clk) begin
        if (pv) begin
            rd_mesi = cur.mesi[pw];
            rd_lru  = cur.lru[pw];
            rd_tag  = cur.tag[pw];
        end else begin
            rd_mesi = 2'($urandom);
            rd_lru  = 3'($urandom);
            rd_tag  = 12'($urandom);
        end
        pv = rd_en_o;
        pw = rd_way_o;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic void model(inout vec_t v);
        int inv = -1;
        int best = 0;
        for (int i = WAYS - 1; i >= 0; i--) if (v.mesi[i] == 2'b00) inv = i;
        if (inv >= 0) begin
            v.e_way = inv; v.e_evict = 0; v.e_wb = 0; v.e_cyc = inv + 3;
            return;
        end
        for (int i = 1; i < WAYS; i++) if (v.lru[i] > v.lru[best]) best = i;
        v.e_way   = best;
        v.e_evict = 1;
        v.e_wb    = v.mesi[best] == 2'b11;
        v.e_tag   = v.tag[best];
        v.e_cyc   = v.e_wb ? v.wb_start + 1 : WAYS + 2;
    endfunction

    task automatic do_req(input vec_t v, input bit hold, input logic [13:0] idx2);
        int a_cyc = 0, a_way = 0, a_ev = 0, n_alloc = 0, n_rd = 0;
        int wb_first = 0, wb_last = 0, bad_wb = 0, bad_rd = 0, bad_rdy = 0, bad_idx = 0;
        int exp_rd;
        cur = v;
        @(negedge clk);
        chk("ready_idle", int'(req_ready_o), 1);
        req_valid = 1'b1; req_index = v.idx; wb_ready = 1'b0;
        @(posedge clk);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (hold) begin req_valid = 1'b1; req_index = idx2; end
            else req_valid = 1'b0;
            wb_ready = c >= v.wb_start;
            if (rd_index_o !== v.idx) bad_idx++;
            if (rd_en_o) begin
                n_rd++;
                if (c > WAYS || int'(rd_way_o) != c - 1) bad_rd++;
            end
            if (c == 1 && !rd_en_o) bad_rd++;
            if (wb_valid_o) begin
                if (wb_first == 0) wb_first = c;
                wb_last = c;
                if (int'(wb_way_o) != v.e_way || wb_tag_o !== v.e_tag || wb_index_o !== v.idx) bad_wb++;
            end
            if (alloc_valid_o) begin
                n_alloc++;
                if (a_cyc == 0) begin a_cyc = c; a_way = int'(alloc_way_o); a_ev = int'(alloc_evict_o); end
            end
            if (a_cyc != 0 && c == a_cyc + 1) begin
                chk("ready_after_alloc", int'(req_ready_o), 1);
                chk("alloc_one_cycle", int'(alloc_valid_o), 0);
                break;
            end
            if (req_ready_o) bad_rdy++;
        end
        exp_rd = v.e_evict ? WAYS : (v.e_way + 2 < WAYS ? v.e_way + 2 : WAYS);
        chk("alloc_cycle", a_cyc, v.e_cyc);
        chk("alloc_way", a_way, v.e_way);
        chk("alloc_evict", a_ev, int'(v.e_evict));
        chk("alloc_count", n_alloc, 1);
        chk("read_count", n_rd, exp_rd);
        chk("read_order", bad_rd, 0);
        chk("rd_index", bad_idx, 0);
        chk("ready_busy_low", bad_rdy, 0);
        chk("wb_first", wb_first, v.e_wb ? 10 : 0);
        chk("wb_last", wb_last, v.e_wb ? v.wb_start : 0);
        chk("wb_fields", bad_wb, 0);
    endtask

    initial begin
        int seen;
        vec_t v;
        for (int t = 0; t < 5; t++) begin
            tbl[t].idx = 14'(100 + t); tbl[t].wb_start = 99; tbl[t].e_tag = '0; tbl[t].e_wb = 0;
            for (int i = 0; i < WAYS; i++) begin
                tbl[t].tag[i] = 12'($urandom);
                tbl[t].lru[i] = 3'(i);
            end
        end
        tbl[0].idx = 14'd5; tbl[0].mesi = '0;
        tbl[0].e_way = 0; tbl[0].e_evict = 0; tbl[0].e_cyc = 3;
        tbl[1].mesi = {8{2'b01}}; tbl[1].mesi[7] = 2'b00;
        tbl[1].e_way = 7; tbl[1].e_evict = 0; tbl[1].e_cyc = 10;
        tbl[2].mesi = {8{2'b10}};
        for (int i = 0; i < WAYS; i++) tbl[2].lru[i] = 3'(i < 3 ? i : (i == 3 ? 7 : i - 1));
        tbl[2].e_way = 3; tbl[2].e_evict = 1; tbl[2].e_cyc = 10;
        tbl[3].mesi = {8{2'b01}}; tbl[3].mesi[5] = 2'b11; tbl[3].tag[5] = 12'h111; tbl[3].wb_start = 14;
        for (int i = 0; i < WAYS; i++) tbl[3].lru[i] = 3'(i < 5 ? i : (i == 5 ? 7 : i - 1));
        tbl[3].e_way = 5; tbl[3].e_evict = 1; tbl[3].e_wb = 1; tbl[3].e_cyc = 15; tbl[3].e_tag = 12'h111;
        tbl[4].mesi = {8{2'b10}};
        for (int i = 0; i < WAYS; i++) tbl[4].lru[i] = 3'(i < 2 ? 6 : i - 2);
        tbl[4].e_way = 0; tbl[4].e_evict = 1; tbl[4].e_cyc = 10;
        cur = tbl[0];

        repeat (3) @(negedge clk);
        chk("reset_ready", int'(req_ready_o), 0);
        chk("reset_outputs", int'({rd_en_o, wb_valid_o, alloc_valid_o}), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", int'(req_ready_o), 1);

        for (int t = 0; t < 5; t++) do_req(tbl[t], 1'b0, '0);

        // reset while the writeback is pending
        cur = tbl[3];
        @(negedge clk);
        req_valid = 1'b1; req_index = tbl[3].idx; wb_ready = 1'b0;
        @(posedge clk);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (c == 10) chk("rst_case_wb_up", int'(wb_valid_o), 1);
        end
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_wb_low", int'(wb_valid_o), 0);
        chk("rst_ready_low", int'(req_ready_o), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready_back", int'(req_ready_o), 1);
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            seen += int'(alloc_valid_o) + int'(wb_valid_o);
        end
        chk("rst_no_grant", seen, 0);

        // request held with a second index while busy
        do_req(tbl[2], 1'b1, 14'h2abc);
        @(negedge clk);
        chk("hold_accept_index", int'(rd_index_o), 'h2abc);
        chk("hold_accept_read", int'({rd_en_o, rd_way_o}), 8);
        chk("hold_accept_busy", int'(req_ready_o), 0);
        req_valid = 1'b0;
        seen = 0;
        for (int c = 0; c < 30 && seen == 0; c++) begin
            @(negedge clk);
            if (alloc_valid_o) seen = 1;
        end
        chk("hold_second_alloc", seen, 1);

        for (int r = 0; r < 40; r++) begin
            int p[8];
            bit full = $urandom_range(0, 2) != 0;
            v.idx = 14'($urandom); v.wb_start = 10 + $urandom_range(0, 4); v.e_tag = '0;
            for (int i = 0; i < WAYS; i++) begin
                p[i] = i;
                v.mesi[i] = full ? 2'($urandom_range(1, 3)) : 2'($urandom_range(0, 3));
                v.tag[i] = 12'($urandom);
            end
            for (int i = WAYS - 1; i > 0; i--) begin
                int j = $urandom_range(0, i);
                int s = p[i];
                p[i] = p[j]; p[j] = s;
            end
            for (int i = 0; i < WAYS; i++) v.lru[i] = (r % 4 == 3) ? 3'($urandom) : 3'(p[i]);
            model(v);
            do_req(v, 1'b0, '0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/way_alloc_ctrl.md
# way_alloc_ctrl

Allocation controller for the L2 set-associative arrays. On a miss it sequences a way-by-way scan of one set's MESI/LRU state and picks the fill way: the lowest-numbered invalid way, or else the LRU way. If the victim is Modified, it runs a writeback handshake before granting the way. It sits between the miss handler and the tag/MESI/LRU arrays, and is the sequential counterpart of the empty-way and LRU lookup functions.

## Interface
- WAYS, 8, associativity (power of two)
- WAY_BITS, 3, log2(WAYS)
- INDEX_BITS, 14, set index width
- TAG_BITS, 12, tag width
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  1  allocation request
- req_ready  out  1  high only in IDLE
- req_index  in  INDEX_BITS  set to allocate in
- rd_en  out  1  array read strobe
- rd_index  out  INDEX_BITS  latched request index
- rd_way  out  WAY_BITS  way being read
- rd_mesi  in  2  MESI of the way read last cycle (I=00, S=01, E=10, M=11)
- rd_lru  in  WAY_BITS  LRU rank of that way (0 = MRU, WAYS-1 = LRU)
- rd_tag  in  TAG_BITS  tag of that way
- wb_valid  out  1  writeback request for the victim
- wb_ready  in  1  writeback accepted
- wb_index  out  INDEX_BITS  victim index
- wb_tag  out  TAG_BITS  victim tag
- wb_way  out  WAY_BITS  victim way
- alloc_valid  out  1  one-cycle grant pulse
- alloc_way  out  WAY_BITS  granted way
- alloc_evict  out  1  granted way held a valid line

## Operation
- **States:** IDLE, SCAN, WB, DONE. All outputs are registered.
- **IDLE:** req_ready=1. On req_valid, latch req_index, clear the way counter, clear the best-rank tracker, go to SCAN.
- **SCAN:** rd_en=1 and rd_way=counter each cycle. The counter increments up to WAYS-1. After the last issue, rd_en=0 while waiting for the final response.
- **Scan responses:** the response for way k arrives the cycle after its issue.
  - If rd_mesi==I: victim=k, evict=0, go to DONE at once. Reads still in flight are ignored and no further reads are issued.
  - Otherwise, if rd_lru is greater than the best rank so far, record way k, its rank, its tag and whether it is M. Ties keep the lower way index.
- **After the way WAYS-1 response with no invalid way:** victim = tracked way, evict=1. Go to WB if the victim is M, else to DONE.
- **WB:** wb_valid=1 with victim index, tag and way, held stable until the edge where wb_ready=1. Then go to DONE.
- **DONE:** alloc_valid=1 for exactly one cycle with alloc_way and alloc_evict. Then go to IDLE.
- **Busy requests:** req_valid while not in IDLE is ignored; the requester must hold it.
- **Reset:** rst_n low at any edge forces IDLE. All outputs are 0 the following cycle, including req_ready. The in-flight operation is abandoned with no grant and no writeback completion. req_ready=1 in the first cycle after rst_n returns high.
- **Corrupt ranks:** if no way reports WAYS-1, the highest rank seen wins, lowest index on ties.

## Timing
- Cycle 0 is the accept edge (req_valid & req_ready).
- Way k is read in cycle k+1; its response is sampled at the end of cycle k+2.
- First invalid way k: alloc_valid in cycle k+3. Way 0 invalid gives latency 3.
- Full set, clean victim: alloc_valid in cycle WAYS+2 (10).
- Full set, Modified victim:
  - wb_valid rises in cycle 10.
  - If wb_ready is sampled high in cycle n, wb_valid=0 and alloc_valid=1 in cycle n+1.
- req_ready is 0 from cycle 1 until the cycle after alloc_valid.
- Back-to-back requests: the next accept is possible in the cycle following alloc_valid.

## Test plan
- **All ways invalid, req_index=5:** rd_index=5; reads of ways 0 and 1 issued in cycles 1–2; alloc_way=0, alloc_evict=0, alloc_valid in cycle 3 only; wb_valid never asserted.
- **Ways 0–6 S, way 7 I:** alloc_way=7, alloc_evict=0, alloc_valid in cycle 10; no writeback.
- **All ways E, way 3 rank 7, others ranks 0–6:** alloc_way=3, alloc_evict=1, alloc_valid in cycle 10, wb_valid stays 0.
- **All ways valid, way 5 M with rank 7 and rd_tag=12'h111, wb_ready low until cycle 14:**
  - wb_valid=1 in cycles 10–14, with wb_way=5, wb_tag=12'h111, wb_index stable.
  - alloc_valid with alloc_way=5 in cycle 15.
- **rst_n low in cycle 12 of the previous case:** wb_valid=0 and req_ready=0 in cycle 13; no alloc_valid ever; req_ready=1 in the first cycle after rst_n returns high.
- **req_valid held during a scan with a second index:** ignored until the cycle after alloc_valid, then accepted. Separately, all ways valid with ranks 6,6,0..5 (no rank 7): alloc_way=0.
